// File: rtl/qupls4_copydst_engine.sv
// Copy-target engine: for each flagged ROB entry copies pRd into nRd through one
// register-file read port and one write port, then releases nRd and acks the entry.
module qupls4_copydst_engine #(
  parameter int ROB_ENTRIES = 16,
  parameter int PREG_BITS   = 9,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ROB_ENTRIES-1:0]           copydst,
  input  logic [ROB_ENTRIES*PREG_BITS-1:0] rob_nrd,
  input  logic [ROB_ENTRIES*PREG_BITS-1:0] rob_prd,
  input  logic [$clog2(ROB_ENTRIES)-1:0]   head,
  output logic                             rf_rd_req,
  output logic [PREG_BITS-1:0]             rf_rd_preg,
  input  logic                             rf_rd_ack,
  input  logic [DATA_WIDTH-1:0]            rf_rd_data,
  output logic                             rf_wr_req,
  output logic [PREG_BITS-1:0]             rf_wr_preg,
  output logic [DATA_WIDTH-1:0]            rf_wr_data,
  input  logic                             rf_wr_ack,
  output logic                             release_v,
  output logic [PREG_BITS-1:0]             release_preg,
  output logic [ROB_ENTRIES-1:0]           copy_done,
  output logic                             busy
);

  localparam int IDX_BITS = $clog2(ROB_ENTRIES);

  // Handshake: a request is held with stable index/data until the matching
  // ack is seen high at a rising clock edge; that edge completes the transfer.
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                  state, state_nx;
  logic [ROB_ENTRIES-1:0]  pend;
  logic [ROB_ENTRIES-1:0]  clr;
  logic [IDX_BITS-1:0]     sel;
  logic [PREG_BITS-1:0]    cur_nrd, cur_prd;
  logic [DATA_WIDTH-1:0]   cur_data;

  logic                    found;
  logic [IDX_BITS-1:0]     pick;
  logic [PREG_BITS-1:0]    pick_nrd, pick_prd;
  logic [ROB_ENTRIES-1:0]  sel_onehot;
  int                      idx;

  // Age-ordered pick: scan downward so the entry closest to head wins last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = ROB_ENTRIES - 1; k >= 0; k--) begin
      idx = (int'(head) + k) % ROB_ENTRIES;
      if (pend[idx]) begin
        found = 1'b1;
        pick  = IDX_BITS'(idx);
      end
    end
  end

  assign pick_nrd   = rob_nrd[pick*PREG_BITS +: PREG_BITS];
  assign pick_prd   = rob_prd[pick*PREG_BITS +: PREG_BITS];
  assign sel_onehot = {{(ROB_ENTRIES-1){1'b0}}, 1'b1} << sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (found) begin
          if (pick_prd == pick_nrd)  state_nx = DONE;
          else if (pick_prd == '0)   state_nx = WR;
          else                       state_nx = RD;
        end
      end
      RD:      if (rf_rd_ack) state_nx = WR;
      WR:      if (rf_wr_ack) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rf_rd_req    = 1'b0;
    rf_rd_preg   = '0;
    rf_wr_req    = 1'b0;
    rf_wr_preg   = '0;
    rf_wr_data   = '0;
    release_v    = 1'b0;
    release_preg = '0;
    copy_done    = '0;
    clr          = '0;
    case (state)
      RD: begin
        rf_rd_req  = 1'b1;
        rf_rd_preg = cur_prd;
      end
      WR: begin
        rf_wr_req  = 1'b1;
        rf_wr_preg = cur_nrd;
        rf_wr_data = cur_data;
      end
      DONE: begin
        release_v    = 1'b1;
        release_preg = cur_nrd;
        copy_done    = sel_onehot;
        clr          = sel_onehot;
      end
      default: ;
    endcase
  end

  // An entry stays in pend until its DONE cycle, which suppresses duplicates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= (pend | copydst) & ~clr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= '0;
      cur_nrd  <= '0;
      cur_prd  <= '0;
      cur_data <= '0;
    end else begin
      if (state == IDLE && found) begin
        sel      <= pick;
        cur_nrd  <= pick_nrd;
        cur_prd  <= pick_prd;
        cur_data <= '0;
      end else if (state == RD && rf_rd_ack) begin
        cur_data <= rf_rd_data;
      end
    end
  end

  assign busy = (pend != '0) | (state != IDLE);

endmodule

// File: tb/tb_qupls4_copydst_engine.sv
// Directed bench for qupls4_copydst_engine with a queue-based scoreboard monitor.
module tb_qupls4_copydst_engine;

  localparam int N  = 16;
  localparam int PB = 9;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    copydst = '0;
  logic [N*PB-1:0] rob_nrd, rob_prd;
  logic [3:0]      head = '0;
  logic            rf_rd_req, rf_rd_ack;
  logic [PB-1:0]   rf_rd_preg;
  logic [DW-1:0]   rf_rd_data;
  logic            rf_wr_req, rf_wr_ack;
  logic [PB-1:0]   rf_wr_preg;
  logic [DW-1:0]   rf_wr_data;
  logic            release_v;
  logic [PB-1:0]   release_preg;
  logic [N-1:0]    copy_done;
  logic            busy;

  logic [PB-1:0]   nrd_t [N];
  logic [PB-1:0]   prd_t [N];
  logic [DW-1:0]   mem [1 << PB];
  logic            rd_stall = 1'b0;
  logic            wr_stall = 1'b0;

  logic [PB-1:0]      rd_q[$];
  logic [PB+DW-1:0]   wr_q[$];
  logic [N+PB-1:0]    done_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int cap = 0;
  int done_cyc = 0;
  int done_cnt [N];

  qupls4_copydst_engine #(.ROB_ENTRIES(N), .PREG_BITS(PB), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .copydst(copydst), .rob_nrd(rob_nrd), .rob_prd(rob_prd),
    .head(head), .rf_rd_req(rf_rd_req), .rf_rd_preg(rf_rd_preg), .rf_rd_ack(rf_rd_ack),
    .rf_rd_data(rf_rd_data), .rf_wr_req(rf_wr_req), .rf_wr_preg(rf_wr_preg),
    .rf_wr_data(rf_wr_data), .rf_wr_ack(rf_wr_ack), .release_v(release_v),
    .release_preg(release_preg), .copy_done(copy_done), .busy(busy)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file responder
  assign rf_rd_ack  = rf_rd_req & ~rd_stall;
  assign rf_wr_ack  = rf_wr_req & ~wr_stall;
  assign rf_rd_data = mem[rf_rd_preg];

  always_comb begin
    rob_nrd = '0;
    rob_prd = '0;
    for (int i = 0; i < N; i++) begin
      rob_nrd[i*PB +: PB] = nrd_t[i];
      rob_prd[i*PB +: PB] = prd_t[i];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic expect_copy(input int e);
    logic [N-1:0] oh;
    oh = '0;
    oh[e] = 1'b1;
    if (prd_t[e] != nrd_t[e]) begin
      if (prd_t[e] != '0) begin
        rd_q.push_back(prd_t[e]);
        wr_q.push_back({nrd_t[e], mem[prd_t[e]]});
      end else begin
        wr_q.push_back({nrd_t[e], {DW{1'b0}}});
      end
    end
    done_q.push_back({oh, nrd_t[e]});
  endtask

  task automatic pulse(input logic [N-1:0] m);
    @(negedge clk);
    copydst = m;
    @(posedge clk);
    #1 cap = cyc;
    @(negedge clk);
    copydst = '0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #2;
      if (!busy && done_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_idle"}, {busy, ok}, {1'b0, 1'b1});
    chk({name, "_queues"}, rd_q.size() + wr_q.size() + done_q.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (rf_rd_req) begin
        if (rd_q.size() == 0) chk("rd_unexpected", rf_rd_req, 0);
        else begin
          chk("rd_preg", rf_rd_preg, rd_q[0]);
          if (rf_rd_ack) void'(rd_q.pop_front());
        end
      end
      if (rf_wr_req) begin
        if (wr_q.size() == 0) chk("wr_unexpected", rf_wr_req, 0);
        else begin
          chk("wr_preg_data", {rf_wr_preg, rf_wr_data}, wr_q[0]);
          if (rf_wr_ack) void'(wr_q.pop_front());
        end
      end
      if (release_v) begin
        if (done_q.size() == 0) chk("release_unexpected", release_v, 0);
        else chk("done_release", {copy_done, release_preg}, done_q.pop_front());
        done_cyc = cyc;
        for (int i = 0; i < N; i++) if (copy_done[i]) done_cnt[i]++;
      end else if (copy_done != '0) begin
        chk("stray_done", copy_done, 0);
      end
    end
  end

  initial begin
    int d3, d7, d8;
    bit seen;
    for (int i = 0; i < (1 << PB); i++) mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    mem[40] = 64'hDEAD_BEEF;
    for (int i = 0; i < N; i++) begin
      nrd_t[i] = PB'(300 + i);
      prd_t[i] = PB'(400 + i);
      done_cnt[i] = 0;
    end
    nrd_t[3] = 77;   prd_t[3] = 40;
    nrd_t[14] = 200; prd_t[14] = 100;
    nrd_t[15] = 201; prd_t[15] = 101;
    nrd_t[2] = 202;  prd_t[2] = 102;
    nrd_t[5] = 20;   prd_t[5] = 20;
    nrd_t[6] = 33;   prd_t[6] = 0;
    nrd_t[7] = 170;  prd_t[7] = 70;
    nrd_t[8] = 180;  prd_t[8] = 80;
    nrd_t[9] = 60;   prd_t[9] = 50;

    // Reset then idle
    repeat (2) @(negedge clk);
    chk("reset_reqs", {rf_rd_req, rf_wr_req, release_v, busy}, 4'b0000);
    chk("reset_idx", {rf_rd_preg, rf_wr_preg, release_preg, copy_done}, 0);
    chk("reset_wdata", rf_wr_data, 0);
    rst = 1'b0;

    // Single copy with latency
    expect_copy(3);
    pulse(16'h0008);
    wait_idle("single");
    chk("single_latency", done_cyc - cap, 3);

    // Age order with wrap
    head = 4'd14;
    expect_copy(14);
    expect_copy(15);
    expect_copy(2);
    pulse(16'h C004);
    wait_idle("wrap");
    head = 4'd0;

    // prd == nrd and prd == 0
    expect_copy(5);
    pulse(16'h0020);
    wait_idle("same_reg");
    expect_copy(6);
    pulse(16'h0040);
    wait_idle("zero_src");

    // Read backpressure with copydst held high
    d3 = done_cnt[3];
    rd_stall = 1'b1;
    expect_copy(3);
    @(negedge clk);
    copydst = 16'h0008;
    repeat (7) @(negedge clk);
    #2 chk("bp_rd_held", {rf_rd_req, rf_rd_preg}, {1'b1, 9'd40});
    @(negedge clk);
    rd_stall = 1'b0;
    copydst = '0;
    wait_idle("backpressure");
    chk("bp_one_done", done_cnt[3] - d3, 1);

    // copydst in DONE cycle
    d7 = done_cnt[7];
    d8 = done_cnt[8];
    expect_copy(7);
    pulse(16'h0080);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (release_v) begin
        seen = 1'b1;
        break;
      end
    end
    chk("sim_done_seen", seen, 1);
    copydst = 16'h0180;
    expect_copy(8);
    @(negedge clk);
    copydst = '0;
    wait_idle("simultaneous");
    chk("sim_counts", {done_cnt[7] - d7, done_cnt[8] - d8}, {32'd1, 32'd1});

    // Async reset while in WR
    wr_stall = 1'b1;
    expect_copy(9);
    pulse(16'h0200);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (rf_wr_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_reached_wr", seen, 1);
    #1 rst = 1'b1;
    #1 chk("rst_async_drop", {rf_wr_req, rf_wr_preg, busy, release_v}, 0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr_stall = 1'b0;
    repeat (3) @(negedge clk);
    #2 chk("post_rst_idle", {busy, rf_rd_req, rf_wr_req, release_v}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
